// File: rtl/coeff_fetch_engine.sv
// Burst read engine: walks a strided address sequence through a 1-cycle-latency
// coefficient ROM and streams the returned words out through a credit-managed FIFO.
module coeff_fetch_engine #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_base,
    input  logic [ADDR_W-1:0] req_len,
    input  logic [7:0]        req_stride,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_ren,
    input  logic [DATA_W-1:0] rom_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic [1:0]        dbg_state
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    // Handshakes: a transfer happens on any rising edge where valid and ready
    // are both high; valid must then stay asserted with stable payload until it does.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic                w_done;

    logic [ADDR_W-1:0]   r_cur_addr;
    logic [ADDR_W-1:0]   r_remaining;
    logic [7:0]          r_stride;
    logic [ADDR_W-1:0]   r_last_addr;
    logic                r_pend;
    logic                r_pend_last;

    logic [DATA_W-1:0]   r_mem_data [FIFO_DEPTH];
    logic                r_mem_last [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_count;

    logic                w_accept;
    logic                w_credit;
    logic                w_issue;
    logic                w_push;
    logic                w_pop;
    logic                w_drained;
    logic                w_last_issue;

    assign w_accept     = req_valid && (r_state == S_IDLE);
    // Credits count buffered words plus the read in flight; a same-cycle pop is not credited.
    assign w_credit     = (r_count + CNT_W'(r_pend)) < CNT_W'(FIFO_DEPTH);
    assign w_issue      = (r_state == S_FETCH) && w_credit;
    assign w_last_issue = w_issue && (r_remaining == ADDR_W'(1));
    assign w_push       = r_pend;
    assign w_pop        = out_valid && out_ready;
    assign w_drained    = (r_count == '0) && !r_pend;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_next_state = (req_len != '0) ? S_FETCH : S_DRAIN;
                end
            end
            S_FETCH: begin
                if (w_last_issue) begin
                    w_next_state = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_drained) begin
                    w_done       = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cur_addr  <= '0;
            r_remaining <= '0;
            r_stride    <= '0;
            r_last_addr <= '0;
            r_pend      <= 1'b0;
            r_pend_last <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cur_addr  <= req_base;
                r_remaining <= req_len;
                r_stride    <= req_stride;
            end else if (w_issue) begin
                r_cur_addr  <= r_cur_addr + ADDR_W'(r_stride);
                r_remaining <= r_remaining - ADDR_W'(1);
                r_last_addr <= r_cur_addr;
            end
            r_pend      <= w_issue;
            r_pend_last <= w_last_issue;
        end
    end

    // The ROM answer lands one cycle after issue and is written straight into the FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem_data[i] <= '0;
                r_mem_last[i] <= 1'b0;
            end
        end else begin
            if (w_push) begin
                r_mem_data[r_wr_ptr] <= rom_rdata;
                r_mem_last[r_wr_ptr] <= r_pend_last;
                r_wr_ptr             <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign rom_ren   = w_issue;
    assign rom_addr  = w_issue ? r_cur_addr : r_last_addr;
    assign out_valid = (r_count != '0);
    assign out_data  = r_mem_data[r_rd_ptr];
    assign out_last  = r_mem_last[r_rd_ptr];
    assign req_ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign done      = w_done;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_coeff_fetch_engine.sv
// Self-checking bench for coeff_fetch_engine: directed scenarios plus randomized
// descriptors, compared against a plain address/word model of each burst.
module tb_coeff_fetch_engine;

    localparam int ADDR_W    = 12;
    localparam int DATA_W    = 32;
    localparam int DEPTH     = 4;
    localparam int ROM_WORDS = 4096;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_base;
    logic [ADDR_W-1:0] req_len;
    logic [7:0]        req_stride;
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_ren;
    logic [DATA_W-1:0] rom_rdata = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              busy;
    logic              done;
    logic [1:0]        dbg_state;

    int errors = 0;
    int checks = 0;

    coeff_fetch_engine #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_base(req_base), .req_len(req_len), .req_stride(req_stride),
        .rom_addr(rom_addr), .rom_ren(rom_ren), .rom_rdata(rom_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last),
        .busy(busy), .done(done), .dbg_state(dbg_state)
    );

    // ---------------- clock / ROM / consumer ----------------
    always #5 clk = ~clk;

    logic [DATA_W-1:0] rom_mem [ROM_WORDS];
    always @(posedge clk) begin
        if (rom_ren) rom_rdata <= rom_mem[rom_addr];
    end

    bit rnd_mode  = 1'b0;
    bit ready_lvl = 1'b1;
    always begin
        @(posedge clk);
        #1;
        out_ready = rnd_mode ? ($urandom_range(0, 3) != 0) : ready_lvl;
    end

    // ---------------- observation (recorded at negedge) ----------------
    int                cyc = 0;
    logic [ADDR_W-1:0] obs_addr_q[$];
    int                ren_cyc_q[$];
    logic [DATA_W:0]   obs_out_q[$];
    int                acc_cyc_q[$];
    int                done_cyc_q[$];
    int                first_vld_cyc = -1;
    int                outstanding = 0;
    int                max_outstanding = 0;

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (req_valid && req_ready) acc_cyc_q.push_back(cyc);
            if (rom_ren) begin
                obs_addr_q.push_back(rom_addr);
                ren_cyc_q.push_back(cyc);
                outstanding++;
            end
            if (out_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
            if (out_valid && out_ready) begin
                obs_out_q.push_back({out_last, out_data});
                outstanding--;
            end
            if (outstanding > max_outstanding) max_outstanding = outstanding;
            if (done) done_cyc_q.push_back(cyc);
        end
    end

    // ---------------- reference model ----------------
    logic [ADDR_W-1:0] exp_addr_q[$];
    logic [DATA_W:0]   exp_q[$];

    function automatic void model_burst(input int base, input int len, input int stride);
        int a;
        for (int i = 0; i < len; i++) begin
            a = (base + i * stride) % ROM_WORDS;
            exp_addr_q.push_back(a[ADDR_W-1:0]);
            exp_q.push_back({(i == len - 1), rom_mem[a]});
        end
    endfunction

    task automatic clear_obs();
        #1;
        obs_addr_q.delete(); ren_cyc_q.delete(); obs_out_q.delete();
        acc_cyc_q.delete(); done_cyc_q.delete();
        exp_addr_q.delete(); exp_q.delete();
        first_vld_cyc = -1; outstanding = 0; max_outstanding = 0;
    endtask

    // ---------------- drivers ----------------
    task automatic send_desc(input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] len,
                             input logic [7:0] stride);
        bit ok;
        ok = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b1; req_base = base; req_len = len; req_stride = stride;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1'b1; break; end
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL send_accept: descriptor base=%h not accepted, required acceptance within 400 cycles", base);
        end
    endtask

    task automatic wait_done(input int n, input int limit);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (done_cyc_q.size() >= n) begin ok = 1'b1; break; end
        end
        repeat (4) @(negedge clk);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL done_timeout: saw %0d done pulses, required %0d within %0d cycles",
                     done_cyc_q.size(), n, limit);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; req_base = '0; req_len = '0; req_stride = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({req_ready, rom_ren, rom_addr, out_valid, out_last, out_data, busy, done} !==
            {1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_values: rdy=%b ren=%b addr=%h vld=%b last=%b data=%h busy=%b done=%b, required 1 0 000 0 0 0 0 0",
                     req_ready, rom_ren, rom_addr, out_valid, out_last, out_data, busy, done);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: rdy=%b busy=%b, required 1 0", req_ready, busy);
        end
    endtask

    task automatic test_basic();
        int acc;
        ready_lvl = 1'b1;
        clear_obs();
        model_burst(12'h400, 4, 1);
        send_desc(12'h400, 12'd4, 8'd1);
        wait_done(1, 100);
        acc = (acc_cyc_q.size() > 0) ? acc_cyc_q[0] : -100;
        checks++;
        if (obs_addr_q.size() != 4 || obs_out_q.size() != 4) begin
            errors++;
            $display("FAIL basic_counts: reads=%0d words=%0d, required 4 4", obs_addr_q.size(), obs_out_q.size());
        end
        for (int i = 0; i < 4 && i < obs_addr_q.size(); i++) begin
            checks++;
            if (obs_addr_q[i] !== exp_addr_q[i] || ren_cyc_q[i] != acc + 1 + i) begin
                errors++;
                $display("FAIL basic_addr[%0d]: addr=%h cyc=%0d, required addr=%h cyc=%0d",
                         i, obs_addr_q[i], ren_cyc_q[i], exp_addr_q[i], acc + 1 + i);
            end
        end
        for (int i = 0; i < 4 && i < obs_out_q.size(); i++) begin
            checks++;
            if (obs_out_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL basic_word[%0d]: got %h, required %h", i, obs_out_q[i], exp_q[i]);
            end
        end
        checks++;
        if (first_vld_cyc != acc + 3) begin
            errors++;
            $display("FAIL basic_latency: first out_valid cycle %0d, required %0d", first_vld_cyc, acc + 3);
        end
        checks++;
        if (done_cyc_q.size() != 1 || done_cyc_q[0] != acc + 7) begin
            errors++;
            $display("FAIL basic_done: %0d pulses, first at %0d, required 1 at %0d",
                     done_cyc_q.size(), (done_cyc_q.size() > 0) ? done_cyc_q[0] : -1, acc + 7);
        end
    endtask

    task automatic test_backpressure();
        ready_lvl = 1'b0;
        repeat (2) @(posedge clk);
        clear_obs();
        model_burst(12'h123, 10, 1);
        send_desc(12'h123, 12'd10, 8'd1);
        repeat (20) @(negedge clk);
        checks++;
        if (obs_addr_q.size() != DEPTH || obs_out_q.size() != 0) begin
            errors++;
            $display("FAIL bp_stall: reads=%0d words=%0d during stall, required %0d 0",
                     obs_addr_q.size(), obs_out_q.size(), DEPTH);
        end
        ready_lvl = 1'b1;
        wait_done(1, 200);
        checks++;
        if (obs_addr_q.size() != 10 || obs_out_q.size() != 10 || done_cyc_q.size() != 1) begin
            errors++;
            $display("FAIL bp_counts: reads=%0d words=%0d done=%0d, required 10 10 1",
                     obs_addr_q.size(), obs_out_q.size(), done_cyc_q.size());
        end
        for (int i = 0; i < 10 && i < obs_out_q.size() && i < obs_addr_q.size(); i++) begin
            checks++;
            if (obs_out_q[i] !== exp_q[i] || obs_addr_q[i] !== exp_addr_q[i]) begin
                errors++;
                $display("FAIL bp_word[%0d]: addr=%h word=%h, required addr=%h word=%h",
                         i, obs_addr_q[i], obs_out_q[i], exp_addr_q[i], exp_q[i]);
            end
        end
        checks++;
        if (max_outstanding > DEPTH) begin
            errors++;
            $display("FAIL bp_overflow: %0d words buffered, required at most %0d", max_outstanding, DEPTH);
        end
    endtask

    task automatic test_stride_wrap();
        ready_lvl = 1'b1;
        clear_obs();
        model_burst(12'hFFE, 4, 1);
        send_desc(12'hFFE, 12'd4, 8'd1);
        wait_done(1, 100);
        model_burst(12'h000, 3, 8'h80);
        send_desc(12'h000, 12'd3, 8'h80);
        wait_done(2, 100);
        checks++;
        if (obs_addr_q.size() != 7 || obs_out_q.size() != 7) begin
            errors++;
            $display("FAIL wrap_counts: reads=%0d words=%0d, required 7 7", obs_addr_q.size(), obs_out_q.size());
        end
        for (int i = 0; i < 7 && i < obs_addr_q.size() && i < obs_out_q.size(); i++) begin
            checks++;
            if (obs_addr_q[i] !== exp_addr_q[i] || obs_out_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL wrap_addr[%0d]: addr=%h word=%h, required addr=%h word=%h",
                         i, obs_addr_q[i], obs_out_q[i], exp_addr_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_zero_len();
        clear_obs();
        send_desc(12'h123, 12'd0, 8'd5);
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL zero_done: done=%b rdy=%b cycle after accept, required 1 0", done, req_ready);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL zero_ready: done=%b rdy=%b, required 0 1", done, req_ready);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (obs_addr_q.size() != 0 || first_vld_cyc != -1 || done_cyc_q.size() != 1) begin
            errors++;
            $display("FAIL zero_quiet: reads=%0d first_vld=%0d done=%0d, required 0 -1 1",
                     obs_addr_q.size(), first_vld_cyc, done_cyc_q.size());
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        ready_lvl = 1'b1;
        clear_obs();
        send_desc(12'h200, 12'd16, 8'd1);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (obs_addr_q.size() >= 3) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL midrst_issue: %0d reads seen, required 3", obs_addr_q.size());
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({req_ready, rom_ren, rom_addr, out_valid, out_last, out_data, busy, done} !==
            {1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL midrst_values: rdy=%b ren=%b addr=%h vld=%b last=%b data=%h busy=%b done=%b, required 1 0 000 0 0 0 0 0",
                     req_ready, rom_ren, rom_addr, out_valid, out_last, out_data, busy, done);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_release: rdy=%b vld=%b, required 1 0", req_ready, out_valid);
        end
        clear_obs();
        model_burst(12'h300, 2, 1);
        send_desc(12'h300, 12'd2, 8'd1);
        wait_done(1, 100);
        checks++;
        if (obs_out_q.size() != 2 || done_cyc_q.size() != 1) begin
            errors++;
            $display("FAIL midrst_counts: words=%0d done=%0d, required 2 1", obs_out_q.size(), done_cyc_q.size());
        end
        for (int i = 0; i < 2 && i < obs_out_q.size(); i++) begin
            checks++;
            if (obs_out_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL midrst_word[%0d]: got %h, required %h", i, obs_out_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        ready_lvl = 1'b1;
        clear_obs();
        model_burst(12'h500, 3, 2);
        send_desc(12'h500, 12'd3, 8'd2);
        @(posedge clk);
        #1;
        req_valid = 1'b1; req_base = 12'h7AA; req_len = 12'd5; req_stride = 8'd1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_busy: rdy=%b busy=%b while busy, required 0 1", req_ready, busy);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        model_burst(12'h600, 5, 3);
        send_desc(12'h600, 12'd5, 8'd3);
        wait_done(2, 200);
        checks++;
        if (acc_cyc_q.size() != 2 || done_cyc_q.size() != 2 || acc_cyc_q[1] != done_cyc_q[0] + 1) begin
            errors++;
            $display("FAIL b2b_gap: accepts=%0d dones=%0d second accept=%0d, required 2 2 %0d",
                     acc_cyc_q.size(), done_cyc_q.size(),
                     (acc_cyc_q.size() > 1) ? acc_cyc_q[1] : -1,
                     (done_cyc_q.size() > 0) ? done_cyc_q[0] + 1 : -1);
        end
        checks++;
        if (obs_out_q.size() != 8) begin
            errors++;
            $display("FAIL b2b_count: words=%0d, required 8", obs_out_q.size());
        end
        for (int i = 0; i < 8 && i < obs_out_q.size(); i++) begin
            checks++;
            if (obs_out_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL b2b_word[%0d]: got %h, required %h", i, obs_out_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random();
        int n_desc;
        int base, len, stride;
        n_desc = 6;
        rnd_mode = 1'b1;
        clear_obs();
        for (int d = 0; d < n_desc; d++) begin
            base   = $urandom_range(0, ROM_WORDS - 1);
            len    = $urandom_range(0, 24);
            stride = $urandom_range(0, 255);
            model_burst(base, len, stride);
            send_desc(base[ADDR_W-1:0], len[ADDR_W-1:0], stride[7:0]);
        end
        wait_done(n_desc, 3000);
        rnd_mode = 1'b0;
        checks++;
        if (obs_addr_q.size() != exp_addr_q.size() || obs_out_q.size() != exp_q.size() ||
            done_cyc_q.size() != n_desc) begin
            errors++;
            $display("FAIL rand_counts: reads=%0d words=%0d done=%0d, required %0d %0d %0d",
                     obs_addr_q.size(), obs_out_q.size(), done_cyc_q.size(),
                     exp_addr_q.size(), exp_q.size(), n_desc);
        end
        for (int i = 0; i < exp_q.size() && i < obs_out_q.size() && i < obs_addr_q.size(); i++) begin
            checks++;
            if (obs_addr_q[i] !== exp_addr_q[i] || obs_out_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL rand_word[%0d]: addr=%h word=%h, required addr=%h word=%h",
                         i, obs_addr_q[i], obs_out_q[i], exp_addr_q[i], exp_q[i]);
            end
        end
        checks++;
        if (max_outstanding > DEPTH) begin
            errors++;
            $display("FAIL rand_overflow: %0d words buffered, required at most %0d", max_outstanding, DEPTH);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        for (int i = 0; i < ROM_WORDS; i++) rom_mem[i] = $urandom;
        test_reset();
        test_basic();
        test_backpressure();
        test_stride_wrap();
        test_zero_len();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at time %0t, required completion earlier", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
